serial_adder_ctrl: RTL and testbench

//  Bit-serial add sequencer. Drives one external 1-bit full adder (A, B, C in; Sum, Carry out)
//  for WIDTH consecutive cycles, LSB first, to add two WIDTH-bit operands. Sits between the

---
 rtl/serial_adder_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add sequencer. Drives one external combinational full adder
//   for WIDTH cycles, LSB first, and assembles the WIDTH-bit sum plus the
//   final carry. The running carry is registered here.
//
// Parameters
//   WIDTH      operand/result width (>= 2)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, accepted in IDLE or DONE
//   op_a/op_b  operands, latched on an accepted start
//   carry_in   initial carry, latched on an accepted start
//   sub        (SERIAL_ADDER_SUB_EN only) subtract: B inverted, carry forced 1
//   fa_a/fa_b  full-adder A/B inputs (registered LSBs of the shift registers)
//   fa_c       full-adder carry input (registered running carry)
//   fa_sum     full-adder sum output
//   fa_carry   full-adder carry output
//   busy       high while in RUN
//   done       one-cycle pulse in DONE
//   result     sum, valid from done until the next accepted start
//   carry_out  final carry, same validity as result
//
// Configuration macro
//   SERIAL_ADDER_SUB_EN  adds the sub port and subtraction support
// ----------------------------------------------------------------------------
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; full-adder inputs held at 0
// S_RUN  | one bit per cycle through the full adder, LSB first
// S_DONE | result valid, done pulsed; start here chains the next add
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub ? 1'b1 : carry_in;
`else
  assign b_load = op_b;
  assign c_load = carry_in;
`endif

  assign last_bit = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // After WIDTH zero-fill shifts the operand registers are empty, and the
  // carry register is cleared on the last bit, so fa_* fall to 0 outside RUN
  // straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sh  <= op_a;
      b_sh  <= b_load;
      c_reg <= c_load;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      result <= {fa_sum, result[WIDTH-1:1]};
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        c_reg     <= 1'b0;
        carry_out <= fa_carry;
      end else begin
        c_reg <= fa_carry;
      end
    end
  end

  assign fa_a = a_sh[0];
  assign fa_b = b_sh[0];
  assign fa_c = c_reg;
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic         fa_a, fa_b, fa_c, fa_sum, fa_carry;
  logic         busy, done, carry_out;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  // External full adder
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sum(fa_sum), .fa_carry(fa_carry),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An operation is a bit index walking 0..W-1; the expected full-adder carry
  // into bit i is computed arithmetically from the low i operand bits.
  logic         m_active, m_done, m_cout;
  int           m_idx;
  logic [W-1:0] m_a, m_b, m_result;
  logic         m_cin;
  logic [W:0]   m_sum;

  function automatic logic carry_into(input logic [W-1:0] a, b, input logic c, input int i);
    logic [W:0] mask, s, one;
    one  = 1;
    mask = (one << i) - one;
    s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, c};
    return s[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_idx <= 0;
      m_a <= '0; m_b <= '0; m_cin <= 1'b0; m_sum <= '0;
      m_result <= '0; m_cout <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_idx == W - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_result <= m_sum[W-1:0];
          m_cout   <= m_sum[W];
        end
        m_idx <= m_idx + 1;
      end else if (start) begin
        logic [W-1:0] b_eff;
        logic         c_eff;
        b_eff = op_b;
        c_eff = carry_in;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
          b_eff = ~op_b;
          c_eff = 1'b1;
        end
`endif
        m_active <= 1'b1;
        m_idx    <= 0;
        m_a      <= op_a;
        m_b      <= b_eff;
        m_cin    <= c_eff;
        m_sum    <= {1'b0, op_a} + {1'b0, b_eff} + {{W{1'b0}}, c_eff};
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("fa_a", {31'd0, fa_a}, {31'd0, m_active ? m_a[m_idx] : 1'b0});
      check("fa_b", {31'd0, fa_b}, {31'd0, m_active ? m_b[m_idx] : 1'b0});
      check("fa_c", {31'd0, fa_c},
            {31'd0, m_active ? carry_into(m_a, m_b, m_cin, m_idx) : 1'b0});
      if (!m_active) begin
        check("result", {24'd0, result}, {24'd0, m_result});
        check("carry_out", {31'd0, carry_out}, {31'd0, m_cout});
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_done(output logic [W-1:0] r, output logic co,
                           output int dcyc, output int bcyc);
    dcyc = 0; bcyc = 0; r = '0; co = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) begin
        dcyc = n; r = result; co = carry_out;
        break;
      end
    end
    if (dcyc == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, b, input logic c, input logic s,
                       output logic [W-1:0] r, output logic co,
                       output int dcyc, output int bcyc);
    @(posedge clk); #2;
    start = 1'b1; op_a = a; op_b = b; carry_in = c; sub = s;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(r, co, dcyc, bcyc);
  endtask

  logic [W-1:0] r;
  logic         co;
  int           dc, bc, seen_done;

  initial begin
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_fa", {29'd0, fa_a, fa_b, fa_c}, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: basic add and latency
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, r, co, dc, bc);
    check("t1_latency", dc, 9);
    check("t1_result", {24'd0, r}, 32'h96);
    check("t1_cout", {31'd0, co}, 32'd0);

    // 2: carry out, busy length
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, r, co, dc, bc);
    check("t2_result", {24'd0, r}, 32'h00);
    check("t2_cout", {31'd0, co}, 32'd1);
    check("t2_busy_len", bc, 8);

    // 3: full carry chain, then back-to-back from DONE
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, r, co, dc, bc);
    check("t3_result", {24'd0, r}, 32'hFF);
    check("t3_cout", {31'd0, co}, 32'd1);
    start = 1'b1; op_a = 8'h01; op_b = 8'h01; carry_in = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    check("t3_no_idle_gap", {31'd0, busy}, 32'd1);
    wait_done(r, co, dc, bc);
    check("t3b_result", {24'd0, r}, 32'h02);
    check("t3b_cout", {31'd0, co}, 32'd0);

    // 4: start during RUN is ignored
    @(posedge clk); #2;
    start = 1'b1; op_a = 8'h10; op_b = 8'h20; carry_in = 1'b0;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2; start = 1'b1; op_a = 8'hFF;
    @(posedge clk); #2; start = 1'b0;
    wait_done(r, co, dc, bc);
    check("t4_result", {24'd0, r}, 32'h30);

    // 5: reset mid-RUN
    @(posedge clk); #2;
    start = 1'b1; op_a = 8'hA5; op_b = 8'h5A; carry_in = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_result", {24'd0, result}, 32'd0);
    check("t5_cout", {31'd0, carry_out}, 32'd0);
    check("t5_fa", {29'd0, fa_a, fa_b, fa_c}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("t5_idle_after", seen_done, 0);

`ifdef SERIAL_ADDER_SUB_EN
    // 6: subtraction
    do_op(8'h10, 8'h01, 1'b0, 1'b1, r, co, dc, bc);
    check("t6_result", {24'd0, r}, 32'h0F);
    check("t6_cout", {31'd0, co}, 32'd1);
    do_op(8'h01, 8'h02, 1'b0, 1'b1, r, co, dc, bc);
    check("t6b_result", {24'd0, r}, 32'hFF);
    check("t6b_cout", {31'd0, co}, 32'd0);
    sub = 1'b0;
`endif

    // Random phase: model and compare process track everything
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      start    = ($urandom_range(0, 3) == 0);
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      carry_in = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub      = 1'($urandom);
`endif
      rst_n    = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk); #2;
    start = 1'b0; rst_n = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
